slow_frame_receiver: RTL and testbench
======================================

# slow_frame_receiver

Receive-side frame assembler for the slow serial link. It sits directly behind `CDR_10b_8b` and consumes its decoded word stream (`word_tick`, `data`, `comma`, `error`). It rebuilds the 128-bit `payload_t` frame that `SlowTransmitter2` sent and presents it with a one-cycle frame tick, plus error reporting and saturating statistics. It is the receiving counterpart of the transmitter's `payload_i` / `frame_tick_i` interface.

## Interface
- `WORD_TIMEOUT`, default 1023: clock cycles allowed between word ticks inside a frame before the frame is aborted. At 50 MHz and 1 Mbit/s one word takes 500 cycles.
- `clk` input, 1 bit: clock.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `word_tick_i` input, 1 bit: one-cycle strobe from the CDR; the other inputs are valid in that cycle.
- `data_i` input, 8 bits: decoded byte.
- `comma_i` input, 1 bit: the word is the K28.5 comma, i.e. start of frame.
- `error_i` input, 1 bit: the CDR reported a disparity or code error for this word.
- `payload_o` output, `payload_t` (128 bits): last good frame.
- `frame_tick_o` output, 1 bit: one-cycle pulse when `payload_o` updates.
- `frame_error_o` output, 1 bit: one-cycle pulse when a frame is aborted or rejected.
- `good_cnt_o` output, 16 bits: good frames received, saturating.
- `err_cnt_o` output, 16 bits: rejected frames, saturating.

## Operation
- Frame on the wire: comma, then 16 payload bytes, then a CRC byte (only when the CRC is enabled; see Configuration).
- Byte k (k = 0..15) goes to `payload[8k+7:8k]`.
- State machine with three states:
  - HUNT: word ticks without a comma are ignored and counted nowhere. A comma moves to PAYLOAD, clears `byte_cnt`, the shadow register and the CRC.
  - PAYLOAD: each word tick writes `data_i` into the shadow register at `byte_cnt` and increments `byte_cnt`. After byte 15 the next state is CHECK if the CRC is enabled. Otherwise the frame commits and the state returns to HUNT.
  - CHECK: the next word tick compares `data_i` with the computed CRC. On a match the frame commits; on a mismatch it is rejected. Either way the state returns to HUNT.
- Commit: the shadow register is copied to `payload_o`, `frame_tick_o` pulses and `good_cnt_o` increments.
- Reject or abort: `frame_error_o` pulses and `err_cnt_o` increments. `payload_o` is unchanged.
- Abort conditions in PAYLOAD or CHECK:
  - `error_i` on a ticked word: go to HUNT.
  - `comma_i` on a ticked word: count one error, then restart at PAYLOAD with `byte_cnt` = 0. This is a resync and the comma is not lost.
  - Timeout expiry: go to HUNT.
- Precedence when flags coincide on one tick: `error_i` over `comma_i` over data.
- Timeout counter: runs only outside HUNT, clears on every word tick, and aborts when it reaches `WORD_TIMEOUT`.
- Counters saturate at 0xFFFF and do not wrap.

## Timing
- Reset (async, `reset_n` = 0):
  - State goes to HUNT.
  - `payload_o` = 0, `frame_tick_o` = 0, `frame_error_o` = 0, both counters = 0.
  - Reset mid-frame discards the partial frame with no error pulse.
- All outputs are registered.
- `frame_tick_o` and `frame_error_o` assert in the cycle after the triggering word tick, or after the timeout cycle.
- `payload_o` changes in the same cycle that `frame_tick_o` is high.
- There is no back-pressure. A consumer must sample `payload_o` on `frame_tick_o`; it is then stable for at least one full frame time.

## Configuration
- `SLOW_LINK_CRC_EN`:
  - Defined: the frame carries a CRC-8 byte. Polynomial 0x07, init 0x00, MSB-first, computed over payload bytes 0..15. The CHECK state exists.
  - Undefined: there is no CRC byte and no CHECK state. The frame commits on the tick of byte 15.
- The macro must be set identically for the transmitter and the receiver.

## Structure
- Shared package `slow_link_pkg` holds:
  - `payload_t`
  - `PAYLOAD_BYTES` = 16
  - `CRC8_POLY` = 8'h07
  - the state enum `rx_state_t`
- Sub-module `slow_crc8`: combinational byte-wise CRC-8 update with inputs crc_in, byte_in and output crc_out. Only instantiated under `SLOW_LINK_CRC_EN`.

## Test plan
- Reset, then comma + bytes 0x00..0x0F (+ CRC) -> one `frame_tick_o`; `payload_o` = 128'h0F0E..0100; `good_cnt_o` = 1.
- CRC enabled, CRC byte sent as the correct value XOR 0x01 -> `frame_error_o` pulse; `payload_o` unchanged; `err_cnt_o` = 1.
- `error_i` on byte 7 followed by a full clean frame -> one error pulse, then the second frame is accepted intact.
- Comma on byte 10, then 16 bytes (+ CRC) -> `err_cnt_o` = 1 and the new frame is accepted with no extra comma needed.
- Word ticks stop after byte 3 for 1100 cycles (`WORD_TIMEOUT` = 1023) -> error pulse at timeout and state back to HUNT. A non-comma tick afterwards is ignored.
- Preload `good_cnt_o` path with 65 536 good frames, or force 0xFFFF, then send one more good frame -> `good_cnt_o` stays 0xFFFF.
- Deassert `reset_n` mid-frame -> outputs zero immediately and no error pulse.

Source files
------------

// File: rtl/slow_link_pkg.sv
// Shared types and constants for the slow serial link (transmitter and receiver).
// SLOW_LINK_CRC_EN adds the trailing CRC-8 byte and the CHECK state.
package slow_link_pkg;

   localparam int PAYLOAD_BYTES = 16;
   localparam logic [7:0] CRC8_POLY = 8'h07;

   typedef logic [8*PAYLOAD_BYTES-1:0] payload_t;

`ifdef SLOW_LINK_CRC_EN
   typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} rx_state_t;
`else
   typedef enum logic [1:0] {HUNT, PAYLOAD} rx_state_t;
`endif

endpackage

// File: rtl/slow_crc8.sv
// Combinational byte-wise CRC-8 update, MSB first, polynomial CRC8_POLY.
module slow_crc8
   import slow_link_pkg::*;
(
   input  logic [7:0] crc_in,
   input  logic [7:0] byte_in,
   output logic [7:0] crc_out
);

   logic [7:0] stage [0:8];

   assign stage[0] = crc_in ^ byte_in;

   // One shift/XOR step per bit of the incoming byte.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bit
         assign stage[gi+1] = stage[gi][7] ? ({stage[gi][6:0], 1'b0} ^ CRC8_POLY)
                                           : {stage[gi][6:0], 1'b0};
      end
   endgenerate

   assign crc_out = stage[8];

endmodule

// File: rtl/slow_frame_receiver.sv
// Rebuilds 16-byte payload frames from the decoded CDR word stream, with error
// reporting and saturating statistics. Optional CRC-8 trailer under SLOW_LINK_CRC_EN.
module slow_frame_receiver
   import slow_link_pkg::*;
#(
   parameter int WORD_TIMEOUT = 1023
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        word_tick_i,
   input  logic [7:0]  data_i,
   input  logic        comma_i,
   input  logic        error_i,
   output payload_t    payload_o,
   output logic        frame_tick_o,
   output logic        frame_error_o,
   output logic [15:0] good_cnt_o,
   output logic [15:0] err_cnt_o
);

   localparam int TIMER_W = $clog2(WORD_TIMEOUT + 1);

   rx_state_t          state_reg, state_next;
   logic [3:0]         byte_cnt_reg, byte_cnt_next;
   payload_t           shadow_reg, shadow_next;
   logic [TIMER_W-1:0] timer_reg, timer_next;
   payload_t           payload_reg, payload_next;
   logic               frame_tick_reg, frame_tick_next;
   logic               frame_error_reg, frame_error_next;
   logic [15:0]        good_cnt_reg, good_cnt_next;
   logic [15:0]        err_cnt_reg, err_cnt_next;
   logic               commit, reject;

`ifdef SLOW_LINK_CRC_EN
   logic [7:0] crc_reg, crc_next, crc_upd;

   slow_crc8 u_crc (
      .crc_in  (crc_reg),
      .byte_in (data_i),
      .crc_out (crc_upd)
   );
`endif

   always_comb begin
      state_next       = state_reg;
      byte_cnt_next    = byte_cnt_reg;
      shadow_next      = shadow_reg;
      timer_next       = timer_reg;
      payload_next     = payload_reg;
      frame_tick_next  = 1'b0;
      frame_error_next = 1'b0;
      good_cnt_next    = good_cnt_reg;
      err_cnt_next     = err_cnt_reg;
      commit           = 1'b0;
      reject           = 1'b0;
`ifdef SLOW_LINK_CRC_EN
      crc_next         = crc_reg;
`endif

      if (state_reg == HUNT) begin
         timer_next = '0;
         // A comma flagged as a code error is not trusted as a frame start.
         if (word_tick_i && comma_i && !error_i) begin
            state_next    = PAYLOAD;
            byte_cnt_next = '0;
            shadow_next   = '0;
`ifdef SLOW_LINK_CRC_EN
            crc_next      = '0;
`endif
         end
      end else if (word_tick_i) begin
         timer_next = '0;
         if (error_i) begin
            reject     = 1'b1;
            state_next = HUNT;
         end else if (comma_i) begin
            // Resync: the comma itself opens the next frame.
            reject        = 1'b1;
            state_next    = PAYLOAD;
            byte_cnt_next = '0;
            shadow_next   = '0;
`ifdef SLOW_LINK_CRC_EN
            crc_next      = '0;
`endif
         end else begin
            case (state_reg)
               PAYLOAD: begin
                  shadow_next[{byte_cnt_reg, 3'b000} +: 8] = data_i;
                  byte_cnt_next = byte_cnt_reg + 4'd1;
`ifdef SLOW_LINK_CRC_EN
                  crc_next = crc_upd;
                  if (byte_cnt_reg == 4'(PAYLOAD_BYTES - 1)) begin
                     state_next = CHECK;
                  end
`else
                  if (byte_cnt_reg == 4'(PAYLOAD_BYTES - 1)) begin
                     commit     = 1'b1;
                     state_next = HUNT;
                  end
`endif
               end
`ifdef SLOW_LINK_CRC_EN
               CHECK: begin
                  commit     = (data_i == crc_reg);
                  reject     = (data_i != crc_reg);
                  state_next = HUNT;
               end
`endif
               default: state_next = HUNT;
            endcase
         end
      end else if (timer_reg == TIMER_W'(WORD_TIMEOUT)) begin
         reject     = 1'b1;
         state_next = HUNT;
      end else begin
         timer_next = timer_reg + 1'b1;
      end

      if (commit) begin
         payload_next    = shadow_next;
         frame_tick_next = 1'b1;
         if (good_cnt_reg != 16'hFFFF) good_cnt_next = good_cnt_reg + 16'd1;
      end
      if (reject) begin
         frame_error_next = 1'b1;
         if (err_cnt_reg != 16'hFFFF) err_cnt_next = err_cnt_reg + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= HUNT;
         byte_cnt_reg    <= '0;
         shadow_reg      <= '0;
         timer_reg       <= '0;
         payload_reg     <= '0;
         frame_tick_reg  <= 1'b0;
         frame_error_reg <= 1'b0;
         good_cnt_reg    <= '0;
         err_cnt_reg     <= '0;
`ifdef SLOW_LINK_CRC_EN
         crc_reg         <= '0;
`endif
      end else begin
         state_reg       <= state_next;
         byte_cnt_reg    <= byte_cnt_next;
         shadow_reg      <= shadow_next;
         timer_reg       <= timer_next;
         payload_reg     <= payload_next;
         frame_tick_reg  <= frame_tick_next;
         frame_error_reg <= frame_error_next;
         good_cnt_reg    <= good_cnt_next;
         err_cnt_reg     <= err_cnt_next;
`ifdef SLOW_LINK_CRC_EN
         crc_reg         <= crc_next;
`endif
      end
   end

   assign payload_o     = payload_reg;
   assign frame_tick_o  = frame_tick_reg;
   assign frame_error_o = frame_error_reg;
   assign good_cnt_o    = good_cnt_reg;
   assign err_cnt_o     = err_cnt_reg;

endmodule

// File: tb/tb_slow_frame_receiver.sv
// Scoreboard bench for slow_frame_receiver: stimulus pushes expected frame/error
// events, a negedge monitor pops and compares them when the DUT pulses.
module tb_slow_frame_receiver;
   import slow_link_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        word_tick_i = 1'b0;
   logic [7:0]  data_i = 8'h00;
   logic        comma_i = 1'b0;
   logic        error_i = 1'b0;
   payload_t    payload_o;
   logic        frame_tick_o;
   logic        frame_error_o;
   logic [15:0] good_cnt_o;
   logic [15:0] err_cnt_o;

   slow_frame_receiver #(.WORD_TIMEOUT(1023)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .word_tick_i   (word_tick_i),
      .data_i        (data_i),
      .comma_i       (comma_i),
      .error_i       (error_i),
      .payload_o     (payload_o),
      .frame_tick_o  (frame_tick_o),
      .frame_error_o (frame_error_o),
      .good_cnt_o    (good_cnt_o),
      .err_cnt_o     (err_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_err;
      logic [127:0] payload;
      logic [15:0] good;
      logic [15:0] err;
   } exp_t;

   exp_t         exp_q[$];
   int           checks = 0;
   int           errors = 0;
   logic [15:0]  exp_good = 16'd0;
   logic [15:0]  exp_err = 16'd0;
   logic [127:0] exp_payload = '0;
   logic [7:0]   frame_bytes [16];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic push_frame(input logic [127:0] p);
      exp_t e;
      if (exp_good != 16'hFFFF) exp_good = exp_good + 16'd1;
      exp_payload = p;
      e = '{is_err: 1'b0, payload: p, good: exp_good, err: exp_err};
      exp_q.push_back(e);
   endtask

   task automatic push_error();
      exp_t e;
      if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
      e = '{is_err: 1'b1, payload: exp_payload, good: exp_good, err: exp_err};
      exp_q.push_back(e);
   endtask

   task automatic send_word(input logic [7:0] d, input logic c, input logic e);
      @(negedge clk);
      data_i = d; comma_i = c; error_i = e; word_tick_i = 1'b1;
      @(negedge clk);
      word_tick_i = 1'b0; comma_i = 1'b0; error_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic fill(input logic [7:0] base, input logic [7:0] step);
      for (int k = 0; k < 16; k++) frame_bytes[k] = base + 8'(k) * step;
   endtask

   task automatic send_bytes(input int n);
      for (int k = 0; k < n; k++) send_word(frame_bytes[k], 1'b0, 1'b0);
   endtask

   function automatic logic [7:0] crc_of_frame();
      logic [7:0] c = 8'h00;
      for (int k = 0; k < 16; k++) begin
         c = c ^ frame_bytes[k];
         for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   task automatic send_crc(input logic [7:0] flip);
`ifdef SLOW_LINK_CRC_EN
      send_word(crc_of_frame() ^ flip, 1'b0, 1'b0);
`else
      if (flip != 8'h00) $display("note: CRC disabled, corruption %h not sent", flip);
`endif
   endtask

   // Monitor: every output pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (reset_n && (frame_tick_o || frame_error_o)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got tick=%0b err=%0b expected none",
                     frame_tick_o, frame_error_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("event %s payload=%h good=%0d err=%0d",
                     e.is_err ? "error" : "frame", payload_o, good_cnt_o, err_cnt_o);
            check("pulse_kind", {126'd0, frame_error_o, frame_tick_o},
                  {126'd0, e.is_err, !e.is_err});
            check("payload", payload_o, e.payload);
            check("good_cnt", {112'd0, good_cnt_o}, {112'd0, e.good});
            check("err_cnt", {112'd0, err_cnt_o}, {112'd0, e.err});
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("reset_payload", payload_o, '0);
      check("reset_tick", {127'd0, frame_tick_o}, '0);
      check("reset_error", {127'd0, frame_error_o}, '0);
      check("reset_good", {112'd0, good_cnt_o}, '0);
      check("reset_err", {112'd0, err_cnt_o}, '0);

      // Clean frame 0x00..0x0F
      fill(8'h00, 8'h01);
      push_frame(128'h0F0E0D0C0B0A09080706050403020100);
      send_word(8'hBC, 1'b1, 1'b0);
      send_bytes(16);
      send_crc(8'h00);

`ifdef SLOW_LINK_CRC_EN
      // Corrupted CRC byte
      fill(8'h30, 8'h01);
      push_error();
      send_word(8'hBC, 1'b1, 1'b0);
      send_bytes(16);
      send_crc(8'h01);
`endif

      // Code error on byte 7, then a clean frame
      fill(8'h00, 8'h01);
      send_word(8'hBC, 1'b1, 1'b0);
      send_bytes(7);
      push_error();
      send_word(8'h07, 1'b0, 1'b1);
      fill(8'hA0, 8'h01);
      push_frame(128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
      send_word(8'hBC, 1'b1, 1'b0);
      send_bytes(16);
      send_crc(8'h00);

      // Comma on byte 10 resyncs without needing another comma
      fill(8'h00, 8'h01);
      send_word(8'hBC, 1'b1, 1'b0);
      send_bytes(10);
      push_error();
      send_word(8'hBC, 1'b1, 1'b0);
      fill(8'h50, 8'h01);
      push_frame(128'h5F5E5D5C5B5A59585756555453525150);
      send_bytes(16);
      send_crc(8'h00);

      // Word ticks stop after byte 3: timeout abort, then a stray tick is ignored
      fill(8'h00, 8'h01);
      send_word(8'hBC, 1'b1, 1'b0);
      send_bytes(4);
      push_error();
      repeat (1100) @(negedge clk);
      check("timeout_drained", 128'(exp_q.size()), '0);
      send_word(8'h33, 1'b0, 1'b0);
      repeat (20) @(negedge clk);

      // Good counter forced to saturation, one more good frame
      force dut.good_cnt_reg = 16'hFFFF;
      @(posedge clk);
      #1 release dut.good_cnt_reg;
      @(negedge clk);
      exp_good = 16'hFFFF;
      check("forced_good", {112'd0, good_cnt_o}, {112'd0, exp_good});
      fill(8'h00, 8'h11);
      push_frame(128'hFFEEDDCCBBAA99887766554433221100);
      send_word(8'hBC, 1'b1, 1'b0);
      send_bytes(16);
      send_crc(8'h00);
      repeat (3) @(negedge clk);
      check("good_saturated", {112'd0, good_cnt_o}, 128'hFFFF);

      // Reset mid-frame: outputs clear at once, no error pulse
      fill(8'h00, 8'h01);
      send_word(8'hBC, 1'b1, 1'b0);
      send_bytes(5);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_payload", payload_o, '0);
      check("midrst_tick", {127'd0, frame_tick_o}, '0);
      check("midrst_error", {127'd0, frame_error_o}, '0);
      check("midrst_good", {112'd0, good_cnt_o}, '0);
      check("midrst_err", {112'd0, err_cnt_o}, '0);
      exp_good = 16'd0;
      exp_err = 16'd0;
      exp_payload = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      send_bytes(6);
      push_frame(128'h0F0E0D0C0B0A09080706050403020100);
      send_word(8'hBC, 1'b1, 1'b0);
      send_bytes(16);
      send_crc(8'h00);

      repeat (10) @(negedge clk);
      check("queue_empty", 128'(exp_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
